shift_add_mult: RTL and testbench



---
 rtl/shift_add_mult_pkg.sv | 13 +
 rtl/shift_add_mult_ripple_add_n.sv | 43 ++++
 rtl/shift_add_mult.sv | 121 ++++++++++++
 tb/tb_shift_add_mult.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding and default sizes.
package shift_add_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 3;

endpackage

// File: rtl/shift_add_mult_ripple_add_n.sv
// Gate-level ripple-carry adder: a chain of WIDTH full-adder cells.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

module ripple_add_n
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a_i   (a_i[i]),
      .b_i   (b_i[i]),
      .cin_i (carry[i]),
      .sum_o (sum_o[i]),
      .cout_o(carry[i+1])
    );
  end

  assign cout_o = carry[WIDTH];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier, one add/shift per clock (WIDTH cycles).
// Optional macro MULT_ZERO_SKIP_EN: zero operands jump straight to DONE with product 0.
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mq_q, mq_d;
  logic                 c_q, c_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;
  logic [WIDTH-1:0]     step_a;
  logic                 step_c;
  logic [2*WIDTH:0]     shifted;

  ripple_add_n #(.WIDTH(WIDTH)) u_add (
    .a_i   (acc_q),
    .b_i   (m_q),
    .cin_i (1'b0),
    .sum_o (add_sum),
    .cout_o(add_cout)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;

    // Conditional add, then {C, A, Q} shifted right with 0 entering the top
    step_c  = mq_q[0] ? add_cout : 1'b0;
    step_a  = mq_q[0] ? add_sum  : acc_q;
    shifted = {step_c, step_a, mq_q} >> 1;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d   = a;
          mq_d  = b;
          acc_d = '0;
          c_d   = 1'b0;
          cnt_d = '0;
`ifdef MULT_ZERO_SKIP_EN
          if (a == '0 || b == '0) begin
            state_d = DONE;
            prod_d  = '0;
          end else begin
            state_d = CALC;
          end
`else
          state_d = CALC;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        c_d   = shifted[2*WIDTH];
        acc_d = shifted[2*WIDTH-1:WIDTH];
        mq_d  = shifted[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          prod_d  = shifted[2*WIDTH-1:0];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  // C is always cleared by the shift; it is kept as a register but never feeds logic
  logic unused_c;
  assign unused_c = c_q;

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult: stimulus pushes expected products, a monitor pops on done.
module tb_shift_add_mult;

  localparam int W = 4;
`ifdef MULT_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [2*W-1:0] sb[$];
  int opa[$];
  int opb[$];
  int opx[$];

  shift_add_mult #(.WIDTH(W), .CNT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int lat(input int x, input int y);
    return ((x == 0 || y == 0) && SKIP) ? 1 : W + 1;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      chk("done_has_request", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() > 0) chk("product", {24'd0, product}, {24'd0, sb.pop_front()});
    end
  end

  // Issues opa/opb back to back, re-asserting start in each DONE cycle
  task automatic run_stream(input string name);
    int cyc;
    int bcnt;
    @(negedge clk);
    a = W'(opa[0]);
    b = W'(opb[0]);
    start = 1'b1;
    sb.push_back((2*W)'(opx[0]));
    for (int i = 0; i < opa.size(); i++) begin
      cyc = 0;
      bcnt = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (busy) bcnt++;
      end while (!done && cyc < 40);
      chk({name, "_latency"}, cyc, lat(opa[i], opb[i]));
      chk({name, "_busy_cycles"}, bcnt, lat(opa[i], opb[i]) - 1);
      if (i + 1 < opa.size()) begin
        a = W'(opa[i+1]);
        b = W'(opb[i+1]);
        sb.push_back((2*W)'(opx[i+1]));
      end else begin
        start = 1'b0;
      end
    end
    opa.delete();
    opb.delete();
    opx.delete();
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_product", product, 0);

    opa = '{15}; opb = '{15}; opx = '{225};
    run_stream("t15x15");
    opa = '{13}; opb = '{11}; opx = '{143};
    run_stream("t13x11");
    opa = '{0}; opb = '{9}; opx = '{0};
    run_stream("t0x9");

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        opa.push_back(i);
        opb.push_back(j);
        opx.push_back(i * j);
      end
    run_stream("exh");

    // start during CALC is ignored
    @(negedge clk);
    a = 4'd7; b = 4'd5; start = 1'b1;
    sb.push_back(8'd35);
    @(negedge clk);
    chk("ignore_busy", busy, 1);
    a = 4'd2; b = 4'd3;
    @(negedge clk);
    start = 1'b0;
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    chk("ignore_done_pulses", done_cnt - d0, 1);

    // Reset in the 2nd CALC cycle aborts the operation
    @(negedge clk);
    a = 4'd9; b = 4'd9; start = 1'b1;
    sb.push_back(8'd81);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_product", product, 0);
    sb.delete();
    opa = '{3}; opb = '{4}; opx = '{12};
    run_stream("t3x4");

    // start held high: a new operation at every DONE
    opa = '{5, 5, 5}; opb = '{6, 6, 6}; opx = '{30, 30, 30};
    run_stream("hold5x6");

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected finish before 500000");
    $fatal(1);
  end

endmodule
